// File: rtl/grid_io_param_ccff.sv
// grid_io_param_ccff: I/O grid tile with NUM_PADS GPIO subtiles behind one
// configuration-chain segment. Each pad holds two config bits (oe, inv).
// Fabric<->pad paths stay in a safe state until the chain is fully loaded.
// Optional feature macro: GRID_IO_CFG_PARITY_EN adds one even-parity bit at
// the far end of the chain and raises config_error on a bad bitstream.
module grid_io_param_ccff #(
  parameter int   NUM_PADS = 8,
  parameter logic SAFE_IN  = 1'b0
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                ccff_en,
  input  logic                ccff_head,
  output logic                ccff_tail,
  input  logic [NUM_PADS-1:0] outpad,
  output logic [NUM_PADS-1:0] inpad,
  output logic [NUM_PADS-1:0] pad_o,
  output logic [NUM_PADS-1:0] pad_oe,
  input  logic [NUM_PADS-1:0] pad_i,
  output logic                config_done,
  output logic                config_error
);

`ifdef GRID_IO_CFG_PARITY_EN
  localparam int CHAIN_LEN = 2 * NUM_PADS + 1;
`else
  localparam int CHAIN_LEN = 2 * NUM_PADS;
`endif
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 active;

  // State register: chain, bit counter, FSM and registered status flags.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state: everything holds unless ccff_en; the chain shifts toward the tail.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    if (ccff_en) begin
      sr_d = {sr_q[CHAIN_LEN-2:0], ccff_head};
      case (state_q)
        ST_IDLE: begin
          cnt_d   = CNT_ONE;
          state_d = (CNT_ONE == CNT_FULL) ? ST_DONE : ST_LOAD;
        end
        ST_LOAD: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = CNT_FULL;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DONE: begin
          // Reprogramming: a fresh bitstream starts counting from one.
          cnt_d   = CNT_ONE;
          state_d = (CNT_ONE == CNT_FULL) ? ST_DONE : ST_LOAD;
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Status flags: done follows the FSM; error is captured on entry to DONE.
  always_comb begin
    done_d = (state_d == ST_DONE);
`ifdef GRID_IO_CFG_PARITY_EN
    if (state_d != ST_DONE) begin
      err_d = 1'b0;
    end else if (state_q != ST_DONE || ccff_en) begin
      // Even parity over every chain bit, parity bit included.
      err_d = ^sr_d;
    end else begin
      err_d = err_q;
    end
`else
    err_d = 1'b0;
`endif
  end

  assign active       = done_q & ~err_q;
  assign config_done  = done_q;
  assign config_error = err_q;
  assign ccff_tail    = sr_q[CHAIN_LEN-1];

  // Per-pad datapath: oe at even chain index, inv at the odd index above it.
  generate
    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic oe_bit;
      logic inv_bit;
      assign oe_bit     = sr_q[2*gi];
      assign inv_bit    = sr_q[2*gi+1];
      assign pad_oe[gi] = active & oe_bit;
      assign pad_o[gi]  = active & (outpad[gi] ^ inv_bit);
      assign inpad[gi]  = active ? (pad_i[gi] ^ inv_bit) : SAFE_IN;
    end
  endgenerate

endmodule
